// File: rtl/pic_bus_pkg.sv
// Shared types and constants for the two-master PIC host-port arbiter.
package pic_bus_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  // Read data returned on an aborted transfer; sliced to DATA_W (up to 64 bits).
  localparam int ERR_MAX_W = 64;
  localparam logic [ERR_MAX_W-1:0] ERR_RDATA = '1;
endpackage

// File: rtl/pic_bus_arb_if.sv
// Bundle of both master ports and the PIC wrapper port seen by the arbiter.
interface pic_bus_arb_if
  import pic_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  // Handshake: a master holds wen/ren (and address/data) stable until it sees a
  // one-cycle mN_ready; data_out and err are valid only in that ready cycle.
  // Toward the PIC, pic_wen/pic_ren stay high and stable until pic_ready.
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [DATA_W-1:0] m0_data_in, m1_data_in;
  logic              m0_wen, m1_wen, m0_ren, m1_ren;
  logic [DATA_W-1:0] m0_data_out, m1_data_out;
  logic              m0_ready, m1_ready, m0_err, m1_err;
  logic [ADDR_W-1:0] pic_address;
  logic [DATA_W-1:0] pic_data_in;
  logic              pic_wen, pic_ren;
  logic [DATA_W-1:0] pic_data_out;
  logic              pic_ready;

  modport master (
    output m0_address, m1_address, m0_data_in, m1_data_in,
    output m0_wen, m1_wen, m0_ren, m1_ren, pic_data_out, pic_ready,
    input  m0_data_out, m1_data_out, m0_ready, m1_ready, m0_err, m1_err,
    input  pic_address, pic_data_in, pic_wen, pic_ren
  );

  modport slave (
    input  m0_address, m1_address, m0_data_in, m1_data_in,
    input  m0_wen, m1_wen, m0_ren, m1_ren, pic_data_out, pic_ready,
    output m0_data_out, m1_data_out, m0_ready, m1_ready, m0_err, m1_err,
    output pic_address, pic_data_in, pic_wen, pic_ren
  );
endinterface

// File: rtl/pic_rr_arb2.sv
// Two-input round-robin picker; the last-grant pointer lives in the parent.
module pic_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end
endmodule

// File: rtl/pic_bus_arb.sv
// Shares the PIC host port between two masters: round-robin grant, registered
// transfer toward the PIC, response routed to the owner, timeout abort.
module pic_bus_arb
  import pic_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  pic_bus_arb_if.slave bus,
  output arb_state_e   state_o
);
  // Abort fires in the BUSY cycle whose count is TIMEOUT-1, so the abort ready
  // appears TIMEOUT cycles after the strobe first went high.
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ERR_DATA = ERR_RDATA[DATA_W-1:0];

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wen_q, wen_d, ren_q, ren_d;
  logic [1:0]        rdy_q, rdy_d, err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [1:0]        req, gnt;
  logic              sel_wen, sel_ren, resp_err;
  logic [DATA_W-1:0] resp_data;

  assign req = {bus.m1_wen | bus.m1_ren, bus.m0_wen | bus.m0_ren};

  pic_rr_arb2 u_rr (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen_d     = wen_q;
    ren_d     = ren_q;
    rdy_d     = 2'b00;
    err_d     = 2'b00;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    sel_wen   = 1'b0;
    sel_ren   = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          last_d  = gnt[1];
          addr_d  = gnt[1] ? bus.m1_address : bus.m0_address;
          wdata_d = gnt[1] ? bus.m1_data_in : bus.m0_data_in;
          sel_wen = gnt[1] ? bus.m1_wen : bus.m0_wen;
          sel_ren = gnt[1] ? bus.m1_ren : bus.m0_ren;
          wen_d   = sel_wen;
          ren_d   = ~sel_wen & sel_ren;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // pic_ready takes priority over a timeout landing in the same cycle.
        if (bus.pic_ready || (cnt_q == TO_LAST)) begin
          resp_err  = ~bus.pic_ready;
          resp_data = bus.pic_ready ? (wen_q ? '0 : bus.pic_data_out) : ERR_DATA;
          rdy_d[owner_q] = 1'b1;
          err_d[owner_q] = resp_err;
          if (owner_q) rdata1_d = resp_data;
          else         rdata0_d = resp_data;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      rdy_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.pic_address = addr_q;
  assign bus.pic_data_in = wdata_q;
  assign bus.pic_wen     = wen_q;
  assign bus.pic_ren     = ren_q;
  assign bus.m0_ready    = rdy_q[0];
  assign bus.m1_ready    = rdy_q[1];
  assign bus.m0_err      = err_q[0];
  assign bus.m1_err      = err_q[1];
  assign bus.m0_data_out = rdata0_q;
  assign bus.m1_data_out = rdata1_q;
  assign state_o         = state_q;
endmodule

// File: tb/tb_pic_bus_arb.sv
// Self-checking bench for pic_bus_arb: scenario tasks plus a completion scoreboard.
module tb_pic_bus_arb;
  import pic_bus_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  arb_state_e state;
  int         vectors = 0;
  int         miscompares = 0;
  logic [DW:0] exp0_q[$];
  logic [DW:0] exp1_q[$];
  logic [DW:0] mon_e;

  pic_bus_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  pic_bus_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard: every ready pulse consumes one expectation ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.m0_ready) begin
        vectors++;
        if (exp0_q.size() == 0) begin
          miscompares++; $display("FAIL sb_m0_stray: m0_ready=1 with no transfer outstanding");
        end else begin
          mon_e = exp0_q.pop_front();
          if ({bus.m0_err, bus.m0_data_out} !== mon_e) begin
            miscompares++; $display("FAIL sb_m0: got err=%b data=%h want err=%b data=%h", bus.m0_err, bus.m0_data_out, mon_e[DW], mon_e[DW-1:0]);
          end
        end
      end
      if (bus.m1_ready) begin
        vectors++;
        if (exp1_q.size() == 0) begin
          miscompares++; $display("FAIL sb_m1_stray: m1_ready=1 with no transfer outstanding");
        end else begin
          mon_e = exp1_q.pop_front();
          if ({bus.m1_err, bus.m1_data_out} !== mon_e) begin
            miscompares++; $display("FAIL sb_m1: got err=%b data=%h want err=%b data=%h", bus.m1_err, bus.m1_data_out, mon_e[DW], mon_e[DW-1:0]);
          end
        end
      end
      if ((bus.m0_err && !bus.m0_ready) || (bus.m1_err && !bus.m1_ready)) begin
        vectors++; miscompares++;
        $display("FAIL sb_err_without_ready: m0_err=%b m1_err=%b", bus.m0_err, bus.m1_err);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_address = '0; bus.m1_address = '0;
    bus.m0_data_in = '0; bus.m1_data_in = '0;
    bus.m0_wen = 1'b0; bus.m1_wen = 1'b0;
    bus.m0_ren = 1'b0; bus.m1_ren = 1'b0;
    bus.pic_data_out = '0; bus.pic_ready = 1'b0;
  endtask

  function automatic logic all_outputs_zero();
    return ({bus.pic_address, bus.pic_data_in, bus.pic_wen, bus.pic_ren,
             bus.m0_ready, bus.m1_ready, bus.m0_err, bus.m1_err,
             bus.m0_data_out, bus.m1_data_out} == '0) && (state == IDLE);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic seen;
    idle_inputs();
    reset_n = 1'b0;
    step(3);
    vectors++; if (all_outputs_zero() !== 1'b1) begin miscompares++; $display("FAIL reset_state: outputs not all zero, state=%0d", state); end
    reset_n = 1'b1;
    step(1);
    bus.m0_wen = 1'b1; bus.m0_address = 16'h0077; bus.m0_data_in = 32'h1111_2222;
    step(1);
    vectors++; if ({bus.pic_wen, state} !== {1'b1, BUSY}) begin miscompares++; $display("FAIL abort_setup: pic_wen=%b state=%0d want 1/BUSY", bus.pic_wen, state); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (all_outputs_zero() !== 1'b1) begin miscompares++; $display("FAIL reset_async: pic_wen=%b pic_addr=%h state=%0d want all zero", bus.pic_wen, bus.pic_address, state); end
    bus.m0_wen = 1'b0;
    step(2);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      seen = seen | bus.m0_ready | bus.m1_ready;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL reset_no_stray_ready: got ready pulse after release, want none"); end
  endtask

  task automatic test_single_read();
    bus.m0_ren = 1'b1; bus.m0_address = 16'h0010;
    step(1);
    vectors++; if ({bus.pic_ren, bus.pic_wen} !== 2'b10) begin miscompares++; $display("FAIL rd_strobe: pic_ren/wen=%b%b want 10", bus.pic_ren, bus.pic_wen); end
    vectors++; if (bus.pic_address !== 16'h0010) begin miscompares++; $display("FAIL rd_addr: got %h want 0010", bus.pic_address); end
    exp0_q.push_back({1'b0, 32'hDEAD_BEEF});
    step(2);
    bus.pic_ready = 1'b1; bus.pic_data_out = 32'hDEAD_BEEF;
    step(1);
    bus.pic_ready = 1'b0; bus.pic_data_out = '0;
    vectors++; if ({bus.m0_ready, bus.m0_err, bus.m0_data_out} !== {2'b10, 32'hDEAD_BEEF}) begin miscompares++; $display("FAIL rd_resp: ready=%b err=%b data=%h want 1/0/deadbeef", bus.m0_ready, bus.m0_err, bus.m0_data_out); end
    vectors++; if ({bus.m1_ready, bus.pic_ren, state} !== {2'b00, DONE}) begin miscompares++; $display("FAIL rd_after: m1_ready=%b pic_ren=%b state=%0d want 0/0/DONE", bus.m1_ready, bus.pic_ren, state); end
    bus.m0_ren = 1'b0;
    step(1);
    vectors++; if ({bus.m0_ready, state} !== {1'b0, IDLE}) begin miscompares++; $display("FAIL rd_pulse_width: m0_ready=%b state=%0d want 0/IDLE", bus.m0_ready, state); end
  endtask

  task automatic test_contention();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    idle_inputs();
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    bus.m0_wen = 1'b1; bus.m0_address = 16'h0100; bus.m0_data_in = 32'hA0A0_0000;
    bus.m1_wen = 1'b1; bus.m1_address = 16'h0200; bus.m1_data_in = 32'hB1B1_0000;
    step(1);
    for (int k = 0; k < 4; k++) begin
      ea = (k % 2 == 1) ? 16'h0200 : 16'h0100;
      ed = (k % 2 == 1) ? 32'hB1B1_0000 : 32'hA0A0_0000;
      vectors++; if ({state, bus.pic_wen, bus.pic_address, bus.pic_data_in} !== {BUSY, 1'b1, ea, ed}) begin miscompares++; $display("FAIL cont_grant%0d: state=%0d wen=%b addr=%h data=%h want BUSY/1/%h/%h", k, state, bus.pic_wen, bus.pic_address, bus.pic_data_in, ea, ed); end
      if (k % 2 == 1) exp1_q.push_back('0);
      else            exp0_q.push_back('0);
      bus.pic_ready = 1'b1;
      step(1);
      bus.pic_ready = 1'b0;
      vectors++; if ({bus.m1_ready, bus.m0_ready} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL cont_owner%0d: ready m1m0=%b%b", k, bus.m1_ready, bus.m0_ready); end
      vectors++; if ({state, bus.pic_wen} !== {DONE, 1'b0}) begin miscompares++; $display("FAIL cont_dead%0d: state=%0d wen=%b want DONE/0", k, state, bus.pic_wen); end
      step(1);
      vectors++; if (state !== IDLE) begin miscompares++; $display("FAIL cont_idle%0d: state=%0d want IDLE", k, state); end
      if (k == 3) begin
        bus.m0_wen = 1'b0; bus.m1_wen = 1'b0;
      end
      step(1);
    end
    vectors++; if (state !== IDLE) begin miscompares++; $display("FAIL cont_end: state=%0d want IDLE", state); end
  endtask

  task automatic test_timeout();
    bus.m1_ren = 1'b1; bus.m1_address = 16'h0300;
    step(1);
    vectors++; if ({bus.pic_ren, bus.pic_address} !== {1'b1, 16'h0300}) begin miscompares++; $display("FAIL to_strobe: pic_ren=%b addr=%h want 1/0300", bus.pic_ren, bus.pic_address); end
    exp1_q.push_back({1'b1, 32'hFFFF_FFFF});
    step(3);
    vectors++; if ({bus.pic_ren, bus.m1_ready} !== 2'b10) begin miscompares++; $display("FAIL to_early: pic_ren=%b m1_ready=%b want 1/0", bus.pic_ren, bus.m1_ready); end
    step(1);
    vectors++; if ({bus.m1_ready, bus.m1_err, bus.m1_data_out} !== {2'b11, 32'hFFFF_FFFF}) begin miscompares++; $display("FAIL to_abort: ready=%b err=%b data=%h want 1/1/ffffffff", bus.m1_ready, bus.m1_err, bus.m1_data_out); end
    vectors++; if ({bus.pic_ren, bus.m0_ready, bus.m0_err} !== 3'b000) begin miscompares++; $display("FAIL to_side: pic_ren=%b m0_ready=%b m0_err=%b want 000", bus.pic_ren, bus.m0_ready, bus.m0_err); end
    bus.m1_ren = 1'b0;
    step(1);
  endtask

  task automatic test_race();
    bus.m0_ren = 1'b1; bus.m0_address = 16'h0044;
    step(1);
    vectors++; if (bus.pic_ren !== 1'b1) begin miscompares++; $display("FAIL race_strobe: pic_ren=%b want 1", bus.pic_ren); end
    exp0_q.push_back({1'b0, 32'h1234_5678});
    step(3);
    bus.pic_ready = 1'b1; bus.pic_data_out = 32'h1234_5678;
    step(1);
    bus.pic_ready = 1'b0; bus.pic_data_out = '0;
    vectors++; if ({bus.m0_ready, bus.m0_err, bus.m0_data_out} !== {2'b10, 32'h1234_5678}) begin miscompares++; $display("FAIL race_resp: ready=%b err=%b data=%h want 1/0/12345678", bus.m0_ready, bus.m0_err, bus.m0_data_out); end
    bus.m0_ren = 1'b0;
    step(1);
  endtask

  task automatic test_wen_wins();
    bus.m0_wen = 1'b1; bus.m0_ren = 1'b1; bus.m0_address = 16'h0055; bus.m0_data_in = 32'h5555_AAAA;
    step(1);
    vectors++; if ({bus.pic_wen, bus.pic_ren, bus.pic_data_in} !== {2'b10, 32'h5555_AAAA}) begin miscompares++; $display("FAIL ww_strobe: wen=%b ren=%b data=%h want 1/0/5555aaaa", bus.pic_wen, bus.pic_ren, bus.pic_data_in); end
    exp0_q.push_back('0);
    bus.pic_ready = 1'b1; bus.pic_data_out = 32'hCAFE_F00D;
    step(1);
    bus.pic_ready = 1'b0; bus.pic_data_out = '0;
    vectors++; if ({bus.m0_ready, bus.m0_data_out} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL ww_resp: ready=%b data=%h want 1/00000000", bus.m0_ready, bus.m0_data_out); end
    bus.m0_wen = 1'b0; bus.m0_ren = 1'b0;
    step(1);
  endtask

  task automatic test_ready_outside_busy();
    logic seen;
    seen = 1'b0;
    bus.pic_ready = 1'b1; bus.pic_data_out = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      step(1);
      seen = seen | bus.m0_ready | bus.m1_ready;
    end
    bus.pic_ready = 1'b0; bus.pic_data_out = '0;
    vectors++; if ({seen, state} !== {1'b0, IDLE}) begin miscompares++; $display("FAIL idle_ready: seen_ready=%b state=%0d want 0/IDLE", seen, state); end
    vectors++; if (bus.m0_data_out !== 32'h0) begin miscompares++; $display("FAIL idle_hold: m0_data_out=%h want 00000000", bus.m0_data_out); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_timeout();
    test_race();
    test_wen_wins();
    test_ready_outside_busy();
    step(2);
    vectors++;
    if (exp0_q.size() + exp1_q.size() != 0) begin
      miscompares++; $display("FAIL sb_drain: %0d m0 and %0d m1 completions never seen, want 0", exp0_q.size(), exp1_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pic_bus_arb.md
# pic_bus_arb

Two-master arbiter for the PIC wrapper's host bus port (address/data_in/wen/ren/data_out/ready). Shares the single PIC register/memory port between master 0 (SoC CPU bridge) and master 1 (boot loader / debug port) with round-robin fairness. Registers each granted transfer toward the PIC, returns the response only to its owner, and aborts transfers the PIC never acknowledges.

## Interface
Parameters:
- ADDR_W, 16, address width (matches PIC wrapper address)
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles a transfer may wait for pic_ready before abort (1..2^TO_W-1)
- TO_W, 8, timeout counter width

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  master transfer address
- m0_data_in / m1_data_in  in  DATA_W  master write data
- m0_wen / m1_wen  in  1  write request, held until mN_ready
- m0_ren / m1_ren  in  1  read request, held until mN_ready
- m0_data_out / m1_data_out  out  DATA_W  read data, valid with mN_ready
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  timeout flag, valid with mN_ready
- pic_address  out  ADDR_W  to PIC wrapper
- pic_data_in  out  DATA_W  to PIC wrapper
- pic_wen / pic_ren  out  1  to PIC wrapper, at most one high
- pic_data_out  in  DATA_W  from PIC wrapper
- pic_ready  in  1  from PIC wrapper, transfer acknowledge

## Operation
- Request from master N = mN_wen | mN_ren. Both high: treated as write (wen wins).
- States: IDLE, BUSY, DONE.
- IDLE: if any request, pick winner (round-robin; on tie grant the master not granted last), latch address/data/direction into pic_* registers, assert pic_wen or pic_ren, clear timeout counter, record owner -> BUSY. No request: stay.
- BUSY: pic_* held stable. pic_ready=1 -> latch pic_data_out (reads; writes latch 0), pulse owner ready, err=0, drop pic_wen/pic_ren -> DONE. Counter reaching TIMEOUT without pic_ready -> abort: drop strobes, owner ready=1, err=1, data_out=all ones -> DONE. pic_ready and timeout same cycle: ready wins, err=0.
- DONE: one dead cycle; requests ignored (owner is deasserting). -> IDLE.
- Last-grant pointer updates on each grant; reset value points to master 1 so master 0 wins first tie.
- Non-owner's ready/err never asserted; data_out of non-owner holds last value.
- pic_ready outside BUSY ignored.
- Reset (any state): state IDLE, all pic_* outputs 0, mN_ready/mN_err/mN_data_out 0, counter 0. Aborted transfer produces no ready pulse.

## Timing
- Request sampled cycle C in IDLE -> pic strobe high C+1.
- pic_ready high cycle R -> mN_ready/data_out/err registered, visible R+1; pic strobes low R+1.
- Minimum transfer: request at C, pic_ready at C+1, mN_ready at C+2; next grant sampled C+3 (DONE at C+2).
- Timeout: strobe high C+1, counter increments each BUSY cycle; abort ready visible C+1+TIMEOUT.
- Back-to-back from both masters: grants alternate, 1 dead cycle between transfers.
- All outputs registered; no combinational path master -> pic or pic -> master.

## Structure
- Package pic_bus_pkg: state enum (IDLE/BUSY/DONE), ADDR_W/DATA_W defaults, error read value constant (all ones).
- Sub-module pic_rr_arb2: 2-input round-robin picker (req[1:0], last-grant pointer -> one-hot grant), purely combinational, pointer kept in parent.
- Top holds FSM, transfer registers, timeout counter, response registers.

## Test plan
- Reset: hold reset_n=0 mid-BUSY with pic_wen=1 -> all outputs 0 immediately; after release, no stray ready.
- Single read: m0_ren, m0_address=0x0010; PIC returns 0xDEADBEEF 3 cycles after strobe -> pic_ren high C+1, m0_ready pulse one cycle with m0_data_out=0xDEADBEEF, m0_err=0, m1_ready stays 0.
- Contention: m0 and m1 both write at same cycle, held continuously -> grants m0, m1, m0, m1; pic_address/data match owner each time; one dead cycle between.
- Timeout: TIMEOUT=4, m1_ren, pic_ready never asserted -> m1_ready at C+5 with m1_err=1, m1_data_out=0xFFFFFFFF, pic_ren low at C+5.
- Race: pic_ready asserted on same cycle counter hits TIMEOUT -> normal completion, err=0, read data returned.
- wen+ren both high from m0 -> pic_wen=1, pic_ren=0, m0_data_out=0 on completion.
